decode_stage: RTL

- Pipeline stage 2 (ID) plus the ID/EX pipeline register.
- Consumes the IF/ID register outputs (instruction word and NPC). Decodes the opcode, reads the register file (write-back bypass included) and sign-extends the immediate.
- Registers everything for EX one cycle later.
- Detects load-use hazards and drives the stall request back to the fetch stage and PC.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/reg_file.sv | 50 +++++
 rtl/decode_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and decode types for the ID stage.
package mips_pkg;

   localparam int unsigned REG_W = 5;

   typedef logic [5:0] opcode_t;

   localparam opcode_t OP_RTYPE = 6'h00;
   localparam opcode_t OP_LW    = 6'h23;
   localparam opcode_t OP_SW    = 6'h2B;
   localparam opcode_t OP_BEQ   = 6'h04;
   localparam opcode_t OP_ADDI  = 6'h08;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two async read ports, one posedge write port, $0 hardwired
// to zero and same-cycle write-back bypass onto the read ports.
module reg_file
   import mips_pkg::*;
#(
   parameter int unsigned NREGS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rs_addr_in,
   input  logic [REG_W-1:0] rt_addr_in,
   input  logic             we_in,
   input  logic [REG_W-1:0] w_addr_in,
   input  logic [31:0]      w_data_in,
   output logic [31:0]      rs_data_out,
   output logic [31:0]      rt_data_out
);

   logic [31:0] r_regs [NREGS];
   logic        w_wr_en;

   assign w_wr_en = we_in && (w_addr_in != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         for (int i = 1; i < NREGS; i++) begin
            if (w_addr_in == REG_W'(i)) begin
               r_regs[i] <= w_data_in;
            end
         end
      end
   end

   always_comb begin
      rs_data_out = '0;
      rt_data_out = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (rs_addr_in == REG_W'(i)) rs_data_out = r_regs[i];
         if (rt_addr_in == REG_W'(i)) rt_data_out = r_regs[i];
      end
      // Bypass overrides storage; $0 is excluded because w_wr_en needs a nonzero index.
      if (w_wr_en && (w_addr_in == rs_addr_in)) rs_data_out = w_data_in;
      if (w_wr_en && (w_addr_in == rt_addr_in)) rt_data_out = w_data_in;
   end

endmodule

// File: rtl/decode_stage.sv
// ID stage: opcode decode, register read, sign extension, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_in,
   input  logic [ADDR_W-1:0] NPC_in,
   input  logic              flush_in,
   input  logic              wb_reg_write_in,
   input  logic [REG_W-1:0]  wb_write_reg_in,
   input  logic [31:0]       wb_write_data_in,
   output logic              hazard_out,
   output logic [ADDR_W-1:0] NPC_out,
   output logic [31:0]       read_data1_out,
   output logic [31:0]       read_data2_out,
   output logic [31:0]       sign_ext_out,
   output logic [REG_W-1:0]  rs_out,
   output logic [REG_W-1:0]  rt_out,
   output logic [REG_W-1:0]  rd_out,
   output logic              reg_dst_out,
   output logic              alu_src_out,
   output logic              mem_to_reg_out,
   output logic              reg_write_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic              branch_out,
   output logic [1:0]        alu_op_out,
   output logic              illegal_out
);

   logic [REG_W-1:0]  w_rs, w_rt, w_rd;
   logic [31:0]       w_rd1, w_rd2, w_sext;
   ctrl_t             w_ctrl;
   logic              w_haz;

   logic [ADDR_W-1:0] r_npc;
   logic [31:0]       r_rd1, r_rd2, r_sext;
   logic [REG_W-1:0]  r_rs, r_rt, r_rd;
   ctrl_t             r_ctrl;

   assign w_rs   = instr_in[25:21];
   assign w_rt   = instr_in[20:16];
   assign w_rd   = instr_in[15:11];
   assign w_sext = {{16{instr_in[15]}}, instr_in[15:0]};

   reg_file #(
      .NREGS(NREGS)
   ) u_reg_file (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs_addr_in (w_rs),
      .rt_addr_in (w_rt),
      .we_in      (wb_reg_write_in),
      .w_addr_in  (wb_write_reg_in),
      .w_data_in  (wb_write_data_in),
      .rs_data_out(w_rd1),
      .rt_data_out(w_rd2)
   );

   always_comb begin
      w_ctrl = '0;
      unique case (instr_in[31:26])
         OP_RTYPE: begin
            w_ctrl.reg_dst   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_LW: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_read   = 1'b1;
            w_ctrl.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         OP_BEQ: begin
            w_ctrl.branch = 1'b1;
            w_ctrl.alu_op = ALUOP_SUB;
         end
         OP_ADDI: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         default: w_ctrl.illegal = 1'b1;
      endcase
   end

   // Conservative: compares against rt even for formats that do not read it.
   assign w_haz      = r_ctrl.mem_read && (r_rt != '0) && ((r_rt == w_rs) || (r_rt == w_rt));
   assign hazard_out = w_haz && !flush_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_npc  <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_sext <= '0;
         r_rs   <= '0;
         r_rt   <= '0;
         r_rd   <= '0;
         r_ctrl <= '0;
      end else if (flush_in || hazard_out) begin
         r_npc  <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_sext <= '0;
         r_rs   <= '0;
         r_rt   <= '0;
         r_rd   <= '0;
         r_ctrl <= '0;
      end else begin
         r_npc  <= NPC_in;
         r_rd1  <= w_rd1;
         r_rd2  <= w_rd2;
         r_sext <= w_sext;
         r_rs   <= w_rs;
         r_rt   <= w_rt;
         r_rd   <= w_rd;
         r_ctrl <= w_ctrl;
      end
   end

   assign NPC_out        = r_npc;
   assign read_data1_out = r_rd1;
   assign read_data2_out = r_rd2;
   assign sign_ext_out   = r_sext;
   assign rs_out         = r_rs;
   assign rt_out         = r_rt;
   assign rd_out         = r_rd;
   assign reg_dst_out    = r_ctrl.reg_dst;
   assign alu_src_out    = r_ctrl.alu_src;
   assign mem_to_reg_out = r_ctrl.mem_to_reg;
   assign reg_write_out  = r_ctrl.reg_write;
   assign mem_read_out   = r_ctrl.mem_read;
   assign mem_write_out  = r_ctrl.mem_write;
   assign branch_out     = r_ctrl.branch;
   assign alu_op_out     = r_ctrl.alu_op;
   assign illegal_out    = r_ctrl.illegal;

endmodule
